sync_fifo: RTL and testbench



---
 rtl/sync_fifo_pkg.sv | 12 +
 rtl/sync_fifo_storage.sv | 59 +++++
 rtl/sync_fifo.sv | 117 +++++++++++
 tb/tb_sync_fifo.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared types for the synchronous FWFT FIFO
package sync_fifo_pkg;

  // Accepted operations in one cycle, encoded as {pushed, popped}
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/sync_fifo_storage.sv
// rtl/sync_fifo_storage.sv - FIFO slot storage, one write port, all slots readable
module sync_fifo_storage
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 8,
  parameter int FLOPS_NOT_MEM = 0,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_we,
  input  logic [AW-1:0]          i_waddr,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH*DEPTH-1:0] o_slots
);

  if (FLOPS_NOT_MEM != 0) begin : g_flops
    logic [WIDTH-1:0] slot_q [DEPTH];
    logic [WIDTH-1:0] slot_d [DEPTH];

    // Next slot contents: only the addressed slot takes new data
    always_comb begin
      slot_d = slot_q;
      if (i_we) begin
        slot_d[i_waddr] = i_wdata;
      end
    end

    // Slot registers, cleared on reset so reads are deterministic
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          slot_q[i] <= '0;
        end
      end else begin
        slot_q <= slot_d;
      end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_rd
      assign o_slots[g*WIDTH +: WIDTH] = slot_q[g];
    end
  end else begin : g_mem
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Unreset memory; writes are blocked while reset is held
    always_ff @(posedge i_clk) begin
      if (i_we && !i_rst) begin
        mem_q[i_waddr] <= i_wdata;
      end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_rd
      assign o_slots[g*WIDTH +: WIDTH] = mem_q[g];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous first-word-fall-through FIFO with flush and clock gate
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 8,
  parameter int FLOPS_NOT_MEM = 0,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cg,
  input  logic                   i_flush,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_pushed,
  output logic                   o_popped,
  output logic [AW-1:0]          o_wrptr,
  output logic [AW-1:0]          o_rdptr,
  output logic [DEPTH-1:0]       o_validEntries,
  output logic [AW:0]            o_nEntries,
  output logic [WIDTH*DEPTH-1:0] o_entries
);

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

  logic [AW-1:0]    wrptr_q, wrptr_d;
  logic [AW-1:0]    rdptr_q, rdptr_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW:0]      count_q, count_d;
  fifo_op_e         op;

  // Full/empty come straight from the slot valid bits, so there is no
  // path from i_ready to o_ready or from i_valid to o_valid.
  assign o_ready  = !valid_q[wrptr_q];
  assign o_valid  = valid_q[rdptr_q];
  assign o_pushed = i_cg && !i_flush && i_valid && o_ready;
  assign o_popped = i_cg && !i_flush && i_ready && o_valid;
  assign op       = fifo_op_e'({o_pushed, o_popped});

  assign o_wrptr        = wrptr_q;
  assign o_rdptr        = rdptr_q;
  assign o_validEntries = valid_q;
  assign o_nEntries     = count_q;
  assign o_data         = o_entries[rdptr_q*WIDTH +: WIDTH];

  // Next pointers, valid bitmap and count; flush wins over push/pop
  always_comb begin
    wrptr_d = wrptr_q;
    rdptr_d = rdptr_q;
    valid_d = valid_q;
    count_d = count_q;
    if (i_cg && i_flush) begin
      wrptr_d = '0;
      rdptr_d = '0;
      valid_d = '0;
      count_d = '0;
    end else begin
      case (op)
        OP_PUSH: begin
          valid_d[wrptr_q] = 1'b1;
          wrptr_d          = wrptr_q + PTR_ONE;
          count_d          = count_q + CNT_ONE;
        end
        OP_POP: begin
          valid_d[rdptr_q] = 1'b0;
          rdptr_d          = rdptr_q + PTR_ONE;
          count_d          = count_q - CNT_ONE;
        end
        OP_BOTH: begin
          // Push and pop never target the same slot: one needs it empty,
          // the other needs it full.
          valid_d[wrptr_q] = 1'b1;
          valid_d[rdptr_q] = 1'b0;
          wrptr_d          = wrptr_q + PTR_ONE;
          rdptr_d          = rdptr_q + PTR_ONE;
        end
        default: begin
        end
      endcase
    end
  end

  // Control registers; reset has priority over everything, i_cg=0 holds
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wrptr_q <= '0;
      rdptr_q <= '0;
      valid_q <= '0;
      count_q <= '0;
    end else begin
      wrptr_q <= wrptr_d;
      rdptr_q <= rdptr_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  sync_fifo_storage #(
    .WIDTH         (WIDTH),
    .DEPTH         (DEPTH),
    .FLOPS_NOT_MEM (FLOPS_NOT_MEM)
  ) u_storage (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (o_pushed),
    .i_waddr (wrptr_q),
    .i_wdata (i_data),
    .o_slots (o_entries)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - scoreboard testbench for sync_fifo
module tb_sync_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   cg;
  logic                   flush;
  logic [WIDTH-1:0]       din;
  logic                   vin;
  logic                   rin;
  logic                   o_ready;
  logic [WIDTH-1:0]       o_data;
  logic                   o_valid;
  logic                   o_pushed;
  logic                   o_popped;
  logic [AW-1:0]          o_wrptr;
  logic [AW-1:0]          o_rdptr;
  logic [DEPTH-1:0]       o_validEntries;
  logic [AW:0]            o_nEntries;
  logic [WIDTH*DEPTH-1:0] o_entries;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] sb [$];
  int               m_cnt;
  int               m_wr;
  int               m_rd;
  logic [WIDTH-1:0] m_slot [DEPTH];

  always #5 clk = ~clk;

  sync_fifo #(
    .WIDTH         (WIDTH),
    .DEPTH         (DEPTH),
    .FLOPS_NOT_MEM (1)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_cg           (cg),
    .i_flush        (flush),
    .i_data         (din),
    .i_valid        (vin),
    .o_ready        (o_ready),
    .o_data         (o_data),
    .o_valid        (o_valid),
    .i_ready        (rin),
    .o_pushed       (o_pushed),
    .o_popped       (o_popped),
    .o_wrptr        (o_wrptr),
    .o_rdptr        (o_rdptr),
    .o_validEntries (o_validEntries),
    .o_nEntries     (o_nEntries),
    .o_entries      (o_entries)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DEPTH-1:0] exp_mask();
    logic [DEPTH-1:0] m = '0;
    for (int k = 0; k < m_cnt; k++) m[(m_rd + k) % DEPTH] = 1'b1;
    return m;
  endfunction

  function automatic logic [WIDTH*DEPTH-1:0] exp_entries();
    logic [WIDTH*DEPTH-1:0] e;
    for (int k = 0; k < DEPTH; k++) e[k*WIDTH +: WIDTH] = m_slot[k];
    return e;
  endfunction

  task automatic model_clear(input bit clear_slots);
    m_cnt = 0;
    m_wr  = 0;
    m_rd  = 0;
    sb.delete();
    if (clear_slots) for (int k = 0; k < DEPTH; k++) m_slot[k] = '0;
  endtask

  // One clock cycle: drive, check state against model, predict handshakes, update model
  task automatic cycle(input bit r_st, input bit c, input bit f, input bit v,
                       input logic [WIDTH-1:0] d, input bit rd);
    bit ep, eo;
    @(posedge clk);
    #1;
    rst = r_st; cg = c; flush = f; vin = v; din = d; rin = rd;
    #1;
    chk("nEntries", 64'(o_nEntries), 64'(m_cnt));
    chk("wrptr", 64'(o_wrptr), 64'(m_wr));
    chk("rdptr", 64'(o_rdptr), 64'(m_rd));
    chk("validEntries", 64'(o_validEntries), 64'(exp_mask()));
    chk("ready", 64'(o_ready), 64'(m_cnt < DEPTH));
    chk("valid", 64'(o_valid), 64'(m_cnt > 0));
    chk("entries", 64'(o_entries), 64'(exp_entries()));
    ep = c && !f && v && (m_cnt < DEPTH);
    eo = c && !f && rd && (m_cnt > 0);
    chk("pushed", 64'(o_pushed), 64'(ep));
    chk("popped", 64'(o_popped), 64'(eo));
    if (r_st) begin
      model_clear(1'b1);
    end else if (c && f) begin
      model_clear(1'b0);
    end else begin
      if (ep) begin
        m_slot[m_wr] = d;
        sb.push_back(d);
        m_wr = (m_wr + 1) % DEPTH;
      end
      if (eo) m_rd = (m_rd + 1) % DEPTH;
      m_cnt = m_cnt + int'(ep) - int'(eo);
    end
  endtask

  // Monitor: every accepted pop must present the oldest outstanding entry
  initial begin
    logic [WIDTH-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && o_popped) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_underflow: got pop with data %0h, expected no pop", o_data);
        end else begin
          e = sb.pop_front();
          chk("pop_data", 64'(o_data), 64'(e));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; cg = 1'b1; flush = 1'b0; vin = 1'b0; din = '0; rin = 1'b0;
    model_clear(1'b1);
    repeat (2) @(posedge clk);

    // Reset state, idle cycles
    cycle(0, 1, 0, 0, 8'h00, 0);
    cycle(0, 1, 0, 0, 8'h00, 0);

    // Fill with 0x11..0x18, overflow attempt, drain in order
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 1, 8'(8'h11 + i), 0);
    cycle(0, 1, 0, 1, 8'h99, 0);
    chk("full_mask", 64'(o_validEntries), 64'hFF);
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 0, 0, 8'h00, 1);
    cycle(0, 1, 0, 0, 8'h00, 0);

    // Fill 7, then 20 cycles of simultaneous push/pop through pointer wrap
    for (int i = 0; i < 7; i++) cycle(0, 1, 0, 1, 8'($urandom), 0);
    for (int i = 0; i < 20; i++) cycle(0, 1, 0, 1, 8'($urandom), 1);
    // Top up to full, then push+pop at full: only the pop is accepted
    cycle(0, 1, 0, 1, 8'($urandom), 0);
    cycle(0, 1, 0, 1, 8'hA5, 1);
    cycle(0, 1, 0, 0, 8'h00, 0);

    // Clock gate low freezes everything
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 8'h5A, 1);
    cycle(0, 0, 1, 1, 8'h5B, 1);
    cycle(0, 1, 0, 0, 8'h00, 0);

    // Flush with a concurrent push request
    cycle(0, 1, 1, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 1, 8'(8'h30 + i), 0);
    cycle(0, 1, 1, 1, 8'h77, 0);
    cycle(0, 1, 0, 0, 8'h00, 0);

    // Reset mid-stream with clock gate low
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 1, 8'(8'h40 + i), 0);
    cycle(1, 0, 0, 1, 8'h88, 1);
    cycle(0, 1, 0, 0, 8'h00, 0);

    // Randomised traffic with occasional flushes and gated cycles
    for (int i = 0; i < 600; i++) begin
      cycle(0, ($urandom_range(0, 7) != 0), ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 9) < 6), 8'($urandom), ($urandom_range(0, 9) < 5));
    end
    cycle(0, 1, 0, 0, 8'h00, 0);
    @(negedge clk);
    chk("scoreboard_depth", 64'(sb.size()), 64'(m_cnt));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
